// File: rtl/kf8237_channel_programmer.sv
// kf8237_channel_programmer: programs one 8237 DMA channel through a sequence
// of I/O bus accesses (mask, clear byte pointer, address, count, mode, an
// optional readback of address and count, then unmask). Every access has the
// form SETUP (1 clock), STROBE (WRITE_PULSE clocks), RECOVER (1 clock).
module kf8237_channel_programmer #(
    parameter int WRITE_PULSE = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  channel,
    input  logic [15:0] base_address,
    input  logic [15:0] word_count,
    input  logic [5:0]  mode,
    input  logic        verify_enable,
    input  logic [7:0]  io_data_in,
    output logic [3:0]  io_address,
    output logic [7:0]  io_data_out,
    output logic        chip_select_n,
    output logic        io_write_n,
    output logic        io_read_n,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        RECOVER,
        DONE
    } state_t;

    // Step numbering: 0..6 writes, 7 clear pointer, 8..11 readback, 12 unmask.
    localparam logic [3:0] STEP_MODE   = 4'd6;
    localparam logic [3:0] STEP_VERIFY = 4'd7;
    localparam logic [3:0] STEP_LAST_RD = 4'd11;
    localparam logic [3:0] STEP_UNMASK = 4'd12;
    localparam logic [3:0] LAST_STROBE = 4'(WRITE_PULSE - 1);

    state_t      state_q, state_d;
    logic [3:0]  step_q, step_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  ch_q, ch_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] count_q, count_d;
    logic [5:0]  mode_q, mode_d;
    logic        verify_q, verify_d;
    logic        error_q, error_d;
    logic [3:0]  io_address_q, io_address_d;
    logic [7:0]  io_data_q, io_data_d;
    logic [3:0]  next_step;
    logic        step_rd;

    function automatic logic [3:0] step_port(input logic [3:0] step, input logic [1:0] ch);
        case (step)
            4'd0, 4'd12:                step_port = 4'hA;
            4'd1, 4'd7:                 step_port = 4'hC;
            4'd2, 4'd3, 4'd8, 4'd9:     step_port = {1'b0, ch, 1'b0};
            4'd4, 4'd5, 4'd10, 4'd11:   step_port = {1'b0, ch, 1'b1};
            4'd6:                       step_port = 4'hB;
            default:                    step_port = 4'h0;
        endcase
    endfunction

    // Write data per step; clear-pointer and read steps drive zero.
    function automatic logic [7:0] step_data(input logic [3:0] step, input logic [1:0] ch,
                                             input logic [15:0] a, input logic [15:0] c,
                                             input logic [5:0] md);
        case (step)
            4'd0:    step_data = {5'b0, 1'b1, ch};
            4'd2:    step_data = a[7:0];
            4'd3:    step_data = a[15:8];
            4'd4:    step_data = c[7:0];
            4'd5:    step_data = c[15:8];
            4'd6:    step_data = {md, ch};
            4'd12:   step_data = {5'b0, 1'b0, ch};
            default: step_data = 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] readback_exp(input logic [3:0] step, input logic [15:0] a,
                                                input logic [15:0] c);
        case (step)
            4'd8:    readback_exp = a[7:0];
            4'd9:    readback_exp = a[15:8];
            4'd10:   readback_exp = c[7:0];
            default: readback_exp = c[15:8];
        endcase
    endfunction

    assign step_rd = (step_q >= 4'd8) && (step_q <= STEP_LAST_RD);

    // State and operand registers; reset aborts any access in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            step_q       <= '0;
            cnt_q        <= '0;
            ch_q         <= '0;
            addr_q       <= '0;
            count_q      <= '0;
            mode_q       <= '0;
            verify_q     <= 1'b0;
            error_q      <= 1'b0;
            io_address_q <= '0;
            io_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            cnt_q        <= cnt_d;
            ch_q         <= ch_d;
            addr_q       <= addr_d;
            count_q      <= count_d;
            mode_q       <= mode_d;
            verify_q     <= verify_d;
            error_q      <= error_d;
            io_address_q <= io_address_d;
            io_data_q    <= io_data_d;
        end
    end

    // Step that follows the current one once its RECOVER clock completes.
    always_comb begin
        next_step = step_q + 4'd1;
        if (step_q == STEP_MODE)
            next_step = verify_q ? STEP_VERIFY : STEP_UNMASK;
        else if (step_q == STEP_LAST_RD)
            next_step = STEP_UNMASK;
    end

    // Access sequencer: next state, operand latch, bus address/data load.
    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        cnt_d        = cnt_q;
        ch_d         = ch_q;
        addr_d       = addr_q;
        count_d      = count_q;
        mode_d       = mode_q;
        verify_d     = verify_q;
        error_d      = error_q;
        io_address_d = io_address_q;
        io_data_d    = io_data_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    ch_d         = channel;
                    addr_d       = base_address;
                    count_d      = word_count;
                    mode_d       = mode;
                    verify_d     = verify_enable;
                    error_d      = 1'b0;
                    step_d       = '0;
                    state_d      = SETUP;
                    io_address_d = step_port(4'd0, channel);
                    io_data_d    = step_data(4'd0, channel, base_address, word_count, mode);
                end
            end
            SETUP: begin
                cnt_d   = '0;
                state_d = STROBE;
            end
            STROBE: begin
                if (cnt_q == LAST_STROBE) begin
                    state_d = RECOVER;
                    if (step_rd && (io_data_in != readback_exp(step_q, addr_q, count_q)))
                        error_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RECOVER: begin
                // A failed readback leaves the channel masked.
                if (step_q == STEP_UNMASK || (step_q == STEP_LAST_RD && error_q)) begin
                    state_d = DONE;
                end else begin
                    step_d       = next_step;
                    state_d      = SETUP;
                    io_address_d = step_port(next_step, ch_q);
                    io_data_d    = step_data(next_step, ch_q, addr_q, count_q, mode_q);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign chip_select_n = !((state_q == SETUP) || (state_q == STROBE));
    assign io_write_n    = !((state_q == STROBE) && !step_rd);
    assign io_read_n     = !((state_q == STROBE) && step_rd);
    assign io_address    = io_address_q;
    assign io_data_out   = io_data_q;
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign error         = error_q;

endmodule
